// File: rtl/alu_pkg.sv
// Shared op-code constants, op-class lookup table and sequencer state type
// for the ALU sequencer and its result mux.
package alu_pkg;

    localparam logic [4:0] ALU_OP_ADD  = 5'd0;
    localparam logic [4:0] ALU_OP_SUB  = 5'd1;
    localparam logic [4:0] ALU_OP_ADDU = 5'd2;
    localparam logic [4:0] ALU_OP_SUBU = 5'd3;
    localparam logic [4:0] ALU_OP_SLL  = 5'd4;
    localparam logic [4:0] ALU_OP_SRL  = 5'd5;
    localparam logic [4:0] ALU_OP_SRA  = 5'd6;
    localparam logic [4:0] ALU_OP_SLT  = 5'd7;
    localparam logic [4:0] ALU_OP_SLTU = 5'd8;
    localparam logic [4:0] ALU_OP_EQ   = 5'd9;
    localparam logic [4:0] ALU_OP_NE   = 5'd10;
    localparam logic [4:0] ALU_OP_XOR  = 5'd11;
    localparam logic [4:0] ALU_OP_MUL  = 5'd12;
    localparam logic [4:0] ALU_OP_ROR  = 5'd13;
    localparam logic [4:0] ALU_OP_OR   = 5'd14;
    localparam logic [4:0] ALU_OP_AND  = 5'd15;

    typedef enum logic [2:0] {
        ClassLogic,
        ClassArith,
        ClassShift,
        ClassCmp,
        ClassInvalid
    } op_class_e;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StCapture,
        StDone
    } seq_state_e;

    // Index is the op code; codes 16..31 are unassigned.
    localparam op_class_e OpClassTable [32] = '{
        ClassArith,   ClassArith,   ClassArith,   ClassArith,
        ClassShift,   ClassShift,   ClassShift,   ClassCmp,
        ClassCmp,     ClassCmp,     ClassCmp,     ClassLogic,
        ClassArith,   ClassShift,   ClassLogic,   ClassLogic,
        ClassInvalid, ClassInvalid, ClassInvalid, ClassInvalid,
        ClassInvalid, ClassInvalid, ClassInvalid, ClassInvalid,
        ClassInvalid, ClassInvalid, ClassInvalid, ClassInvalid,
        ClassInvalid, ClassInvalid, ClassInvalid, ClassInvalid
    };

    function automatic op_class_e op_class_of(logic [4:0] code);
        return OpClassTable[code];
    endfunction

endpackage

// File: rtl/alu_result_mux.sv
// Selects the sub-unit result for the latched op class; unknown classes yield 0.
module alu_result_mux
    import alu_pkg::*;
(
    input  logic [2:0]  op_class,
    input  logic [31:0] logop_out,
    input  logic [31:0] arith_out,
    input  logic [31:0] shift_out,
    input  logic [31:0] cmp_out,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        unique case (op_class_e'(op_class))
            ClassLogic: result = logop_out;
            ClassArith: result = arith_out;
            ClassShift: result = shift_out;
            ClassCmp:   result = cmp_out;
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Accepts one ALU operation at a time, drives the sub-units for two cycles,
// captures the class-selected result and holds it until the consumer takes it.
module alu_sequencer
    import alu_pkg::*;
(
    input  logic        soc_clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [4:0]  op_code,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        dat_ready,
    output logic [31:0] ALU_dat1,
    output logic [31:0] ALU_dat2,
    output logic [4:0]  Instruction_to_ALU,
    input  logic [31:0] LogOp_out,
    input  logic [31:0] Arith_out,
    input  logic [31:0] Shift_out,
    input  logic [31:0] Cmp_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err,
    input  logic        flush,
    output logic [15:0] op_count
);

    seq_state_e  state_q;
    op_class_e   op_class_q;
    op_class_e   lookup_class;
    logic [31:0] mux_result;

    assign lookup_class = op_class_of(op_code);

    alu_result_mux u_result_mux (
        .op_class  (op_class_q),
        .logop_out (LogOp_out),
        .arith_out (Arith_out),
        .shift_out (Shift_out),
        .cmp_out   (Cmp_out),
        .result    (mux_result)
    );

    // op_ready is held low for the first cycle after reset release.
    always_ff @(posedge soc_clk or posedge reset) begin
        if (reset) begin
            state_q            <= StIdle;
            op_class_q         <= ClassInvalid;
            op_ready           <= 1'b0;
            dat_ready          <= 1'b0;
            ALU_dat1           <= '0;
            ALU_dat2           <= '0;
            Instruction_to_ALU <= '0;
            res_valid          <= 1'b0;
            res_data           <= '0;
            res_err            <= 1'b0;
            op_count           <= '0;
        end else if (flush) begin
            state_q   <= StIdle;
            op_ready  <= 1'b1;
            dat_ready <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (op_valid && op_ready) begin
                        Instruction_to_ALU <= op_code;
                        ALU_dat1           <= op_a;
                        ALU_dat2           <= op_b;
                        op_class_q         <= lookup_class;
                        op_ready           <= 1'b0;
                        if (lookup_class == ClassInvalid) begin
                            state_q   <= StDone;
                            res_data  <= '0;
                            res_err   <= 1'b1;
                            res_valid <= 1'b1;
                        end else begin
                            state_q   <= StIssue;
                            dat_ready <= 1'b1;
                        end
                    end else begin
                        op_ready <= 1'b1;
                    end
                end
                StIssue: begin
                    state_q <= StCapture;
                end
                StCapture: begin
                    res_data  <= mux_result;
                    res_err   <= 1'b0;
                    dat_ready <= 1'b0;
                    res_valid <= 1'b1;
                    state_q   <= StDone;
                end
                StDone: begin
                    if (res_ready) begin
                        state_q   <= StIdle;
                        res_valid <= 1'b0;
                        op_ready  <= 1'b1;
                        op_count  <= op_count + 16'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
